// File: rtl/swo_tx_arbiter.sv
// rtl/swo_tx_arbiter.sv - SWO UART Tx sequencer sharing the transmitter between packed trace bytes and host bytes
// Optional build macro: SWO_TX_TIMEOUT_EN (abort WAIT_ACK after pTIMEOUT cycles, adds sticky tx_timeout output).
module swo_tx_arbiter #(
    parameter int unsigned pFIFO_AW = 3,
    parameter logic [15:0] pTIMEOUT = 16'd4095
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        nib_valid,
    input  logic [3:0]  nib_data,
    input  logic        nib_sync,
    input  logic        host_req,
    input  logic [7:0]  host_data,
    output logic        host_ack,
    output logic        txd_syn,
    output logic [7:0]  txd_data,
    input  logic        txd_ack,
    output logic        fifo_full,
    output logic        overflow,
    input  logic        overflow_clr,
    output logic        busy,
    output logic [15:0] bytes_sent
`ifdef SWO_TX_TIMEOUT_EN
    ,
    output logic        tx_timeout
`endif
);

    localparam int unsigned DEPTH = 1 << pFIFO_AW;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t            state_q;
    logic              half_q;
    logic [3:0]        low_q;
    logic [pFIFO_AW:0] wr_q;
    logic [pFIFO_AW:0] rd_q;
    logic [7:0]        mem_q [DEPTH];
    logic              overflow_q;
    logic              sel_host_q;
    logic              last_host_q;
    logic              txd_syn_q;
    logic              host_ack_q;
    logic [7:0]        txd_data_q;
    logic [15:0]       bytes_q;

    logic              push_req;
    logic              push_ok;
    logic              drop;
    logic              pop;
    logic              fifo_empty;
    logic              fifo_full_w;

    // FIFO status and push/pop decisions; a pop in the same cycle makes room for a push into a full FIFO
    always_comb begin
        fifo_empty  = (wr_q == rd_q);
        fifo_full_w = (wr_q[pFIFO_AW] != rd_q[pFIFO_AW]) &&
                      (wr_q[pFIFO_AW-1:0] == rd_q[pFIFO_AW-1:0]);
        push_req    = enable && nib_valid && half_q && !nib_sync;
        pop         = (state_q == S_LOAD) && !sel_host_q;
        push_ok     = push_req && (!fifo_full_w || pop);
        drop        = push_req && fifo_full_w && !pop;
    end

    // Nibble packer: first nibble is held as the low half, sync discards any partial byte
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            half_q <= 1'b0;
            low_q  <= 4'h0;
        end else if (!enable) begin
            half_q <= 1'b0;
        end else if (nib_valid && (nib_sync || !half_q)) begin
            low_q  <= nib_data;
            half_q <= 1'b1;
        end else if (nib_valid || nib_sync) begin
            half_q <= 1'b0;
        end
    end

    // Trace FIFO pointers and sticky overflow; a drop beats a clear in the same cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_q       <= '0;
            rd_q       <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) wr_q <= wr_q + 1'b1;
            if (pop)     rd_q <= rd_q + 1'b1;
            if (drop)              overflow_q <= 1'b1;
            else if (overflow_clr) overflow_q <= 1'b0;
        end
    end

    // FIFO storage, not reset: contents are only meaningful between the pointers
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q[pFIFO_AW-1:0]] <= {nib_data, low_q};
    end

`ifdef SWO_TX_TIMEOUT_EN
    logic [15:0] tmo_q;
    logic        tx_timeout_q;
    assign tx_timeout = tx_timeout_q;
`else
    // pTIMEOUT only has meaning in the timeout build
    logic unused_timeout_param;
    assign unused_timeout_param = ^pTIMEOUT;
`endif

    // Transmit sequencer: round-robin grant, one-cycle load, then wait for the UART to finish
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            sel_host_q  <= 1'b0;
            last_host_q <= 1'b1;
            txd_syn_q   <= 1'b0;
            host_ack_q  <= 1'b0;
            txd_data_q  <= 8'h00;
            bytes_q     <= 16'h0000;
`ifdef SWO_TX_TIMEOUT_EN
            tmo_q        <= 16'h0000;
            tx_timeout_q <= 1'b0;
`endif
        end else begin
            txd_syn_q  <= 1'b0;
            host_ack_q <= 1'b0;
`ifdef SWO_TX_TIMEOUT_EN
            if (overflow_clr) tx_timeout_q <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (enable && (host_req || !fifo_empty)) begin
                        sel_host_q <= host_req && (fifo_empty || !last_host_q);
                        state_q    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    // a host request withdrawn after the grant decision sends nothing
                    if (sel_host_q && !host_req) begin
                        state_q <= S_IDLE;
                    end else begin
                        txd_data_q <= sel_host_q ? host_data : mem_q[rd_q[pFIFO_AW-1:0]];
                        txd_syn_q  <= 1'b1;
                        host_ack_q <= sel_host_q;
                        state_q    <= S_WAIT;
`ifdef SWO_TX_TIMEOUT_EN
                        tmo_q      <= 16'h0000;
`endif
                    end
                end
                S_WAIT: begin
                    if (txd_ack) begin
                        bytes_q     <= bytes_q + 16'd1;
                        last_host_q <= sel_host_q;
                        state_q     <= S_IDLE;
                    end
`ifdef SWO_TX_TIMEOUT_EN
                    else if (tmo_q + 16'd1 == pTIMEOUT) begin
                        last_host_q  <= sel_host_q;
                        tx_timeout_q <= 1'b1;
                        state_q      <= S_IDLE;
                    end else begin
                        tmo_q <= tmo_q + 16'd1;
                    end
`endif
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign host_ack   = host_ack_q;
    assign txd_syn    = txd_syn_q;
    assign txd_data   = txd_data_q;
    assign fifo_full  = fifo_full_w;
    assign overflow   = overflow_q;
    assign busy       = (state_q != S_IDLE);
    assign bytes_sent = bytes_q;

endmodule

// File: tb/tb_swo_tx_arbiter.sv
// tb/tb_swo_tx_arbiter.sv - directed and randomized self-checking bench for swo_tx_arbiter
module tb_swo_tx_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        nib_valid;
    logic [3:0]  nib_data;
    logic        nib_sync;
    logic        host_req;
    logic [7:0]  host_data;
    logic        host_ack;
    logic        txd_syn;
    logic [7:0]  txd_data;
    logic        txd_ack;
    logic        fifo_full;
    logic        overflow;
    logic        overflow_clr;
    logic        busy;
    logic [15:0] bytes_sent;
`ifdef SWO_TX_TIMEOUT_EN
    logic        tx_timeout;
`endif

    int tests = 0;
    int fails = 0;

    bit auto_ack = 1'b1;
    bit ack_rand = 1'b0;
    int ack_dly  = 2;

    byte unsigned host_q[$];
    byte unsigned sent_data[$];
    bit           sent_host[$];

    always #5 clk = ~clk;

    swo_tx_arbiter #(
        .pFIFO_AW(3)
`ifdef SWO_TX_TIMEOUT_EN
        , .pTIMEOUT(16'd100)
`endif
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .enable(enable),
        .nib_valid(nib_valid),
        .nib_data(nib_data),
        .nib_sync(nib_sync),
        .host_req(host_req),
        .host_data(host_data),
        .host_ack(host_ack),
        .txd_syn(txd_syn),
        .txd_data(txd_data),
        .txd_ack(txd_ack),
        .fifo_full(fifo_full),
        .overflow(overflow),
        .overflow_clr(overflow_clr),
        .busy(busy),
        .bytes_sent(bytes_sent)
`ifdef SWO_TX_TIMEOUT_EN
        , .tx_timeout(tx_timeout)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // UART model: answers each start pulse with a done pulse after a delay, abandons it if the DUT goes idle
    initial begin
        txd_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (txd_syn) begin
                int d;
                while (!auto_ack && busy) @(negedge clk);
                d = ack_rand ? int'($urandom_range(0, 6)) : ack_dly;
                repeat (d) @(negedge clk);
                if (busy) begin
                    txd_ack = 1'b1;
                    @(negedge clk);
                    txd_ack = 1'b0;
                end
            end
        end
    end

    // Host requester: presents queued bytes one at a time, level request held until ack
    initial begin
        host_req  = 1'b0;
        host_data = 8'h00;
        forever begin
            @(negedge clk);
            #1;
            if (!reset_n) host_req = 1'b0;
            else if (host_req && host_ack) host_req = 1'b0;
            else if (!host_req && host_q.size() != 0) begin
                host_data = host_q.pop_front();
                host_req  = 1'b1;
            end
        end
    end

    // Records every byte handed to the UART and which source supplied it
    initial begin
        forever begin
            @(negedge clk);
            if (txd_syn) begin
                sent_data.push_back(txd_data);
                sent_host.push_back(host_ack);
            end
        end
    end

    task automatic do_reset();
        reset_n      = 1'b0;
        enable       = 1'b0;
        nib_valid    = 1'b0;
        nib_sync     = 1'b0;
        nib_data     = 4'h0;
        overflow_clr = 1'b0;
        auto_ack     = 1'b1;
        ack_rand     = 1'b0;
        ack_dly      = 2;
        host_q.delete();
        repeat (3) @(negedge clk);
        sent_data.delete();
        sent_host.delete();
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic nib(input logic [3:0] v, input bit s);
        nib_valid = 1'b1;
        nib_data  = v;
        nib_sync  = s;
        @(negedge clk);
        nib_valid = 1'b0;
        nib_sync  = 1'b0;
    endtask

    task automatic wait_bytes(input int n, input int budget, input string tag);
        int k = 0;
        while (int'(bytes_sent) != n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(tag, bytes_sent, n);
    endtask

    task automatic wait_sent(input int n, input int budget, input string tag);
        int k = 0;
        while (sent_data.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(tag, sent_data.size(), n);
    endtask

    initial begin
        byte unsigned exp_b[10];
        byte unsigned exp_t[$];
        byte unsigned exp_h[$];
        logic [3:0]   prev;
        logic [3:0]   lo;
        bit           have_lo;
        int           total;

        // reset values
        reset_n = 1'b0; enable = 1'b0; nib_valid = 1'b0; nib_sync = 1'b0;
        nib_data = 4'h0; overflow_clr = 1'b0;
        @(negedge clk);
        chk("rst_txd_syn", txd_syn, 0);
        chk("rst_host_ack", host_ack, 0);
        chk("rst_txd_data", txd_data, 0);
        chk("rst_fifo_full", fifo_full, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_busy", busy, 0);
        chk("rst_bytes_sent", bytes_sent, 0);

        // packing: low nibble first
        do_reset();
        enable = 1'b1;
        ack_dly = 20;
        nib(4'h3, 0); nib(4'hA, 0); nib(4'h5, 0); nib(4'hC, 0);
        wait_bytes(2, 300, "pack_bytes_sent");
        chk("pack_count", sent_data.size(), 2);
        chk("pack_byte0", sent_data[0], 8'hA3);
        chk("pack_byte1", sent_data[1], 8'hC5);

        // sync realignment discards the partial byte
        do_reset();
        enable = 1'b1;
        nib(4'h1, 0); nib(4'h2, 1); nib(4'h7, 0);
        wait_bytes(1, 100, "sync_bytes_sent");
        repeat (30) @(negedge clk);
        chk("sync_count", sent_data.size(), 1);
        chk("sync_byte", sent_data[0], 8'h72);

        // overflow: one in flight, eight buffered, one dropped; drop wins over a simultaneous clear
        do_reset();
        enable = 1'b1;
        auto_ack = 1'b0;
        prev = 4'h0;
        for (int i = 0; i < 20; i++) begin
            logic [3:0] v;
            v = 4'($urandom);
            if (i % 2 == 1) exp_b[i/2] = {v, prev};
            prev = v;
            if (i == 19) overflow_clr = 1'b1;
            nib(v, 0);
            overflow_clr = 1'b0;
        end
        repeat (2) @(negedge clk);
        chk("ovf_fifo_full", fifo_full, 1);
        chk("ovf_drop_wins", overflow, 1);
        chk("ovf_in_flight", sent_data.size(), 1);
        chk("ovf_busy", busy, 1);
        overflow_clr = 1'b1;
        @(negedge clk);
        overflow_clr = 1'b0;
        chk("ovf_cleared", overflow, 0);
        ack_dly = 1;
        auto_ack = 1'b1;
        wait_bytes(9, 400, "ovf_bytes_sent");
        repeat (20) @(negedge clk);
        chk("ovf_sent_count", sent_data.size(), 9);
        chk("ovf_final_bytes", bytes_sent, 9);
        chk("ovf_fifo_drained", fifo_full, 0);
        for (int i = 0; i < 9; i++) chk($sformatf("ovf_byte%0d", i), sent_data[i], exp_b[i]);

        // arbitration: trace wins first tie, then alternates with the last grant
        do_reset();
        enable = 1'b1;
        ack_dly = 3;
        nib(4'h1, 0); nib(4'h2, 0); host_q.push_back(8'h55);
        wait_bytes(2, 200, "arb1_bytes");
        chk("arb1_first", {sent_host[0], sent_data[0]}, {1'b0, 8'h21});
        chk("arb1_second", {sent_host[1], sent_data[1]}, {1'b1, 8'h55});
        nib(4'h4, 0); nib(4'h3, 0); host_q.push_back(8'hAA);
        wait_bytes(4, 200, "arb2_bytes");
        chk("arb2_first", {sent_host[2], sent_data[2]}, {1'b0, 8'h34});
        chk("arb2_second", {sent_host[3], sent_data[3]}, {1'b1, 8'hAA});
        nib(4'h6, 0); nib(4'h5, 0);
        wait_bytes(5, 200, "arb3_bytes");
        chk("arb3_trace", sent_data[4], 8'h56);
        nib(4'h8, 0); nib(4'h7, 0); host_q.push_back(8'h99);
        wait_bytes(7, 200, "arb4_bytes");
        chk("arb4_first", {sent_host[5], sent_data[5]}, {1'b1, 8'h99});
        chk("arb4_second", {sent_host[6], sent_data[6]}, {1'b0, 8'h78});

        // enable dropped mid-transfer: current byte completes, FIFO kept
        do_reset();
        enable = 1'b1;
        ack_dly = 5;
        nib(4'hE, 0); nib(4'hB, 0); nib(4'hD, 0); nib(4'h9, 0);
        wait_sent(1, 50, "en_first_syn");
        enable = 1'b0;
        repeat (40) @(negedge clk);
        chk("en_hold_bytes", bytes_sent, 1);
        chk("en_hold_busy", busy, 0);
        chk("en_hold_sent", sent_data.size(), 1);
        enable = 1'b1;
        wait_bytes(2, 100, "en_resume_bytes");
        chk("en_resume_byte", sent_data[1], 8'h9D);

        // reset while waiting for the UART
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 6; i++) nib(4'(i + 1), 0);
        wait_bytes(1, 100, "mrst_first");
        auto_ack = 1'b0;
        wait_sent(2, 50, "mrst_second_syn");
        repeat (3) @(negedge clk);
        chk("mrst_busy_before", busy, 1);
        reset_n = 1'b0;
        @(negedge clk);
        chk("mrst_txd_syn", txd_syn, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_fifo_full", fifo_full, 0);
        chk("mrst_bytes_sent", bytes_sent, 0);
        sent_data.delete();
        sent_host.delete();
        reset_n = 1'b1;
        auto_ack = 1'b1;
        repeat (30) @(negedge clk);
        chk("mrst_fifo_empty", sent_data.size(), 0);
        chk("mrst_idle", busy, 0);

        // randomized traffic against a byte-stream model of both sources
        do_reset();
        enable = 1'b1;
        ack_rand = 1'b1;
        have_lo = 1'b0;
        lo = 4'h0;
        for (int c = 0; c < 3000; c++) begin
            nib_valid = ($urandom_range(0, 11) == 0);
            nib_data  = 4'($urandom);
            nib_sync  = ($urandom_range(0, 39) == 0);
            if (nib_sync) have_lo = 1'b0;
            if (nib_valid) begin
                if (have_lo) begin
                    exp_t.push_back({nib_data, lo});
                    have_lo = 1'b0;
                end else begin
                    lo = nib_data;
                    have_lo = 1'b1;
                end
            end
            if ($urandom_range(0, 59) == 0) begin
                byte unsigned b;
                b = 8'($urandom);
                host_q.push_back(b);
                exp_h.push_back(b);
            end
            @(negedge clk);
        end
        nib_valid = 1'b0;
        nib_sync  = 1'b0;
        total = exp_t.size() + exp_h.size();
        wait_bytes(total, 3000, "rnd_bytes_sent");
        repeat (20) @(negedge clk);
        chk("rnd_overflow", overflow, 0);
        chk("rnd_sent_count", sent_data.size(), total);
        for (int i = 0; i < sent_data.size(); i++) begin
            logic [8:0] e;
            if (sent_host[i] && exp_h.size() > 0) e = {1'b0, exp_h.pop_front()};
            else if (!sent_host[i] && exp_t.size() > 0) e = {1'b0, exp_t.pop_front()};
            else e = 9'h100;
            chk($sformatf("rnd_byte%0d_%s", i, sent_host[i] ? "host" : "trace"), {1'b0, sent_data[i]}, e);
        end
        chk("rnd_trace_left", exp_t.size(), 0);
        chk("rnd_host_left", exp_h.size(), 0);

`ifdef SWO_TX_TIMEOUT_EN
        // timeout: no ack for 100 cycles in WAIT_ACK
        begin
            int k;
            do_reset();
            enable = 1'b1;
            auto_ack = 1'b0;
            nib(4'h1, 0); nib(4'h2, 0);
            k = 0;
            while (!txd_syn && k < 50) begin
                @(negedge clk);
                k++;
            end
            chk("tmo_syn", txd_syn, 1);
            repeat (99) @(negedge clk);
            chk("tmo_busy_before", busy, 1);
            @(negedge clk);
            chk("tmo_busy_after", busy, 0);
            chk("tmo_flag", tx_timeout, 1);
            chk("tmo_bytes_sent", bytes_sent, 0);
            overflow_clr = 1'b1;
            @(negedge clk);
            overflow_clr = 1'b0;
            chk("tmo_cleared", tx_timeout, 0);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
